minmax_acc: RTL and testbench
=============================

Name: minmax_acc

Overview:
- Streaming reduction stage directly downstream of the ge comparator.
- Consumes a framed stream of 32-bit words and applies a ge-style compare on every beat to track the running maximum and minimum of the frame.
- On the frame's last beat, presents max, min and beat count through a valid/ready result port.
- Feeds the math pipeline's normalisation/range logic.

Parameters:
- WIDTH, 32, data word width.
- SIGNED, 1, 1 = two's-complement compare; 0 = unsigned compare.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  stream word.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the final beat of the frame; only meaningful with in_valid.
- in_ready  output  1  stage can accept a beat.
- out_max  output  WIDTH  frame maximum.
- out_min  output  WIDTH  frame minimum.
- out_count  output  CNT_W  beats in the frame, saturating.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset: async assert clears state to IDLE.
  - out_max, out_min, out_count and out_valid are 0.
  - in_ready is 0 while rst is high.
  - Reset mid-frame or mid-HOLD discards all partial data. No result is emitted for that frame.
- Beat accept: in_valid && in_ready at a rising clk edge.
- in_ready = (state != HOLD) && !rst. It is decoded combinationally from the registered state.
- Compare: ge(a,b) means a >= b, signed or unsigned per SIGNED. Ties go to the newer word.
- State IDLE, on accept:
  - max = min = in_data; count = 1.
  - If in_last, go to HOLD; otherwise go to ACCUM.
- State ACCUM, on accept:
  - max <= ge(in_data,max) ? in_data : max.
  - min <= ge(min,in_data) ? in_data : min.
  - count <= count+1, saturating at all-ones.
  - If in_last, go to HOLD.
- ACCUM with no accept: hold all values.
- State HOLD:
  - out_valid = 1. out_max, out_min and out_count are registered and stable until the handshake.
  - On out_ready, go to IDLE at the next edge. out_valid falls and in_ready rises that cycle.
  - There is no same-cycle bypass, so there is at least one idle cycle between frames.
- Latency: out_valid rises on the edge that accepts the last beat and is visible the cycle after.
- Single-beat frame: max = min = that word, count = 1.
- out_ready held high with no pending result: ignored.
- All outputs are registered. No combinational path from in_* to out_*.

Optional Feature:
- Macro: MINMAX_ACC_INDEX_EN.
- Defined:
  - Adds outputs out_max_idx and out_min_idx, each CNT_W wide.
  - Each gives the zero-based beat index of the word that last updated max/min. Ties resolve to the later index.
  - Reset value is 0. Both load 0 on the first beat and freeze once count saturates.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

Test Plan:
- SIGNED=1 frame 5, -3, 12, 7 (last on 7) -> out_valid 1 cycle after the 7 beat; max=12, min=-3 (0xFFFFFFFD), count=4; with index enabled, max_idx=2, min_idx=1.
- SIGNED=0 frame 0xFFFFFFFF, 1 -> max=0xFFFFFFFF, min=1. SIGNED=1 with the same frame -> max=1, min=0xFFFFFFFF.
- Single beat 42 with in_last, and out_ready held low 10 cycles -> out_valid stays 1 with stable outputs max=min=42, count=1 and in_ready=0. Raise out_ready -> out_valid=0 and in_ready=1 next cycle.
- Ties, frame 9, 9, 9 -> max=min=9, count=3; with index enabled, both idx=2. Gap cycles with in_valid=0 mid-frame -> results unchanged.
- CNT_W=4, 20-beat frame of value 0 -> count=15, saturated with no wrap.
- Assert rst for 1 cycle after 3 beats of a frame, then send frame 100 with last -> only one result appears: max=min=100, count=1.

Source files
------------

// File: rtl/minmax_acc.sv
// minmax_acc: streaming reduction stage that follows the ge comparator.
// Tracks the running max/min and the beat count of each framed input stream,
// and presents the result on a valid/ready port when the frame's last beat is taken.
// Optional feature macro: MINMAX_ACC_INDEX_EN adds out_max_idx/out_min_idx, the
// zero-based beat index of the word that last updated max/min.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACCUM | frame in progress, folding beats into max/min/count
// HOLD  | result presented, waiting for out_ready
module minmax_acc #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
`ifdef MINMAX_ACC_INDEX_EN
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx,
`endif
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, min_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             accept;
  logic             upd_max, upd_min;
  logic             cnt_sat;

  // a >= b under the configured signedness; ties favour the newer word
  function automatic logic ge(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) >= $signed(b);
    else        return a >= b;
  endfunction

  assign in_ready = (state_q != HOLD) && !rst;
  assign accept   = in_valid && in_ready;
  assign upd_max  = ge(in_data, max_q);
  assign upd_min  = ge(min_q, in_data);
  assign cnt_sat  = &count_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? HOLD : ACCUM;
      ACCUM:   if (accept && in_last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // out_valid registered from the next state so it rises with the last-beat edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= (state_d == HOLD);
  end

  // max/min/count datapath; only moves on an accepted beat, so HOLD keeps it stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      min_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        max_q   <= in_data;
        min_q   <= in_data;
        count_q <= CNT_W'(1);
      end else begin
        if (upd_max) max_q <= in_data;
        if (upd_min) min_q <= in_data;
        if (!cnt_sat) count_q <= count_q + CNT_W'(1);
      end
    end
  end

`ifdef MINMAX_ACC_INDEX_EN
  logic [CNT_W-1:0] max_idx_q, min_idx_q;

  // index of the updating beat equals the pre-increment count; frozen once saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        max_idx_q <= '0;
        min_idx_q <= '0;
      end else if (!cnt_sat) begin
        if (upd_max) max_idx_q <= count_q;
        if (upd_min) min_idx_q <= count_q;
      end
    end
  end

  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`endif

  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_count = count_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_minmax_acc.sv
// Bench for minmax_acc: three instances share one stimulus stream
// (signed, unsigned, 4-bit counter); a scoreboard queue holds per-frame expectations.
module tb_minmax_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        s_in_ready, u_in_ready, c_in_ready;
  logic [31:0] s_max, s_min, u_max, u_min, c_max, c_min;
  logic [15:0] s_cnt, u_cnt;
  logic [3:0]  c_cnt;
  logic        s_valid, u_valid, c_valid;
`ifdef MINMAX_ACC_INDEX_EN
  logic [15:0] s_maxi, s_mini, u_maxi, u_mini;
  logic [3:0]  c_maxi, c_mini;
`endif

  always #5 clk = ~clk;

  minmax_acc #(.WIDTH(32), .SIGNED(1'b1), .CNT_W(16)) u_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(s_in_ready), .out_max(s_max), .out_min(s_min), .out_count(s_cnt),
    .out_valid(s_valid),
`ifdef MINMAX_ACC_INDEX_EN
    .out_max_idx(s_maxi), .out_min_idx(s_mini),
`endif
    .out_ready(out_ready));

  minmax_acc #(.WIDTH(32), .SIGNED(1'b0), .CNT_W(16)) u_u (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(u_in_ready), .out_max(u_max), .out_min(u_min), .out_count(u_cnt),
    .out_valid(u_valid),
`ifdef MINMAX_ACC_INDEX_EN
    .out_max_idx(u_maxi), .out_min_idx(u_mini),
`endif
    .out_ready(out_ready));

  minmax_acc #(.WIDTH(32), .SIGNED(1'b1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(c_in_ready), .out_max(c_max), .out_min(c_min), .out_count(c_cnt),
    .out_valid(c_valid),
`ifdef MINMAX_ACC_INDEX_EN
    .out_max_idx(c_maxi), .out_min_idx(c_mini),
`endif
    .out_ready(out_ready));

  typedef struct {
    logic [31:0] smax, smin, umax, umin;
    logic [15:0] cnt, smaxi, smini;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fw[$];
  int          vectors = 0;
  int          miscompares = 0;

  // reference model of one frame in fw, pushed to the scoreboard
  task automatic push_expect();
    exp_t e;
    int n;
    n = fw.size();
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        e.smax = fw[0]; e.smin = fw[0]; e.umax = fw[0]; e.umin = fw[0];
        e.smaxi = 16'd0; e.smini = 16'd0;
      end else begin
        if ($signed(fw[i]) >= $signed(e.smax)) begin e.smax = fw[i]; e.smaxi = 16'(i); end
        if ($signed(e.smin) >= $signed(fw[i])) begin e.smin = fw[i]; e.smini = 16'(i); end
        if (fw[i] >= e.umax) e.umax = fw[i];
        if (e.umin >= fw[i]) e.umin = fw[i];
      end
    end
    e.cnt  = 16'(n);
    e.cnt4 = (n > 15) ? 4'd15 : 4'(n);
    sb.push_back(e);
  endtask

  // drive fw as one frame starting on a negedge, with optional idle gaps between beats
  task automatic send_frame(input int gap);
    int t;
    push_expect();
    for (int i = 0; i < fw.size(); i++) begin
      t = 0;
      while (!s_in_ready && t < 50) begin @(negedge clk); t++; end
      if (!s_in_ready) begin
        vectors++; miscompares++;
        $display("FAIL in_ready_timeout beat %0d in_ready=%b required 1", i, s_in_ready);
      end
      in_valid = 1'b1; in_data = fw[i]; in_last = (i == fw.size() - 1);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      if (gap > 0 && i != fw.size() - 1) begin
        repeat (gap) begin
          vectors++;
          if (s_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_valid got %b required 0", s_valid);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  // check latency, compare against the scoreboard, hold for `hold` cycles, then handshake
  task automatic collect(input int hold);
    exp_t e;
    int t;
    vectors++;
    if (s_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency out_valid got %b required 1", s_valid);
    end
    t = 0;
    while (s_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard_empty got 0 entries required 1");
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (s_max !== e.smax || s_min !== e.smin || s_cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL signed_result got max=%h min=%h cnt=%0d required max=%h min=%h cnt=%0d",
               s_max, s_min, s_cnt, e.smax, e.smin, e.cnt);
    end
    vectors++;
    if (u_max !== e.umax || u_min !== e.umin || u_cnt !== e.cnt || u_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL unsigned_result got max=%h min=%h cnt=%0d v=%b required max=%h min=%h cnt=%0d v=1",
               u_max, u_min, u_cnt, u_valid, e.umax, e.umin, e.cnt);
    end
    vectors++;
    if (c_cnt !== e.cnt4 || c_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL cnt4_result got cnt=%0d v=%b required cnt=%0d v=1", c_cnt, c_valid, e.cnt4);
    end
`ifdef MINMAX_ACC_INDEX_EN
    vectors++;
    if (s_maxi !== e.smaxi || s_mini !== e.smini) begin
      miscompares++;
      $display("FAIL index_result got max_idx=%0d min_idx=%0d required max_idx=%0d min_idx=%0d",
               s_maxi, s_mini, e.smaxi, e.smini);
    end
`endif
    repeat (hold) begin
      @(negedge clk);
      vectors++;
      if (s_valid !== 1'b1 || s_in_ready !== 1'b0 || s_max !== e.smax || s_min !== e.smin ||
          s_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL hold_stable got v=%b rdy=%b max=%h min=%h cnt=%0d required v=1 rdy=0 max=%h min=%h cnt=%0d",
                 s_valid, s_in_ready, s_max, s_min, s_cnt, e.smax, e.smin, e.cnt);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (s_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release got v=%b rdy=%b required v=0 rdy=1", s_valid, s_in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (s_valid !== 1'b0 || s_max !== 32'd0 || s_min !== 32'd0 || s_cnt !== 16'd0 ||
        s_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b max=%h min=%h cnt=%0d rdy=%b required all 0",
               s_valid, s_max, s_min, s_cnt, s_in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release in_ready got %b required 1", s_in_ready);
    end
  endtask

  task automatic test_basic();
    fw = '{32'd5, 32'hFFFF_FFFD, 32'd12, 32'd7};
    send_frame(0);
    collect(0);
  endtask

  task automatic test_signedness();
    fw = '{32'hFFFF_FFFF, 32'd1};
    send_frame(0);
    collect(0);
  endtask

  task automatic test_single_hold();
    fw = '{32'd42};
    send_frame(0);
    collect(10);
  endtask

  task automatic test_ties_gaps();
    fw = '{32'd9, 32'd9, 32'd9};
    send_frame(2);
    collect(0);
    fw = '{32'd3, 32'hFFFF_FF00, 32'd3, 32'd50, 32'hFFFF_FF00};
    send_frame(1);
    collect(1);
  endtask

  task automatic test_saturate();
    fw.delete();
    for (int i = 0; i < 20; i++) fw.push_back(32'd0);
    send_frame(0);
    collect(0);
  endtask

  task automatic test_idle_ready();
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (s_valid !== 1'b0 || s_in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_out_ready got v=%b rdy=%b required v=0 rdy=1", s_valid, s_in_ready);
      end
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(200 + i); in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (s_in_ready !== 1'b0 || s_cnt !== 16'd0 || s_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got rdy=%b cnt=%0d v=%b required rdy=0 cnt=0 v=0",
               s_in_ready, s_cnt, s_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fw = '{32'd100};
    send_frame(0);
    collect(0);
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (s_valid !== 1'b0 || sb.size() != 0) begin
        miscompares++;
        $display("FAIL extra_result got v=%b pending=%0d required v=0 pending=0", s_valid, sb.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signedness();
    test_single_hold();
    test_ties_gaps();
    test_saturate();
    test_idle_ready();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
